// File: rtl/finn_rtl_krnl_final_example_axis_checksum.sv
// Output stage of the vadd stream: forwards result beats through a 2-entry
// skid buffer and reports a lane-wise modular sum, beat count and kept-byte
// count for each packet once every beat has left on the m side.
module finn_rtl_krnl_final_example_axis_checksum #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_COUNT_WIDTH      = 32
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic                            ctrl_start,
  output logic                            busy,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            sum_valid,
  output logic [C_LANE_WIDTH-1:0]         sum_data,
  output logic [C_COUNT_WIDTH-1:0]        beat_count,
  output logic [C_COUNT_WIDTH-1:0]        byte_count
);

  localparam int KEEP_W  = C_AXIS_TDATA_WIDTH / 8;
  localparam int N_LANES = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;
  logic   report;

  // Skid storage: two entries addressed as a tiny circular buffer.
  logic [C_AXIS_TDATA_WIDTH-1:0] data_mem [2];
  logic [KEEP_W-1:0]             keep_mem [2];
  logic                          last_mem [2];
  logic                          wr_ptr, rd_ptr;
  logic [1:0]                    count, count_next;
  logic                          s_ready_q;
  logic                          s_fire, m_fire, m_valid;

  // Per-beat contribution to the statistics.
  logic [C_AXIS_TDATA_WIDTH-1:0] masked;
  logic [C_LANE_WIDTH-1:0]       beat_sum;
  logic [C_COUNT_WIDTH-1:0]      beat_bytes;

  logic [C_LANE_WIDTH-1:0]       sum_q;
  logic [C_COUNT_WIDTH-1:0]      beats_q, bytes_q;
  logic                          sum_valid_q;

  assign m_valid = (count != 2'd0);
  assign s_fire  = s_axis_tvalid & s_ready_q;
  assign m_fire  = m_valid & m_axis_tready;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    count_next = count;
    case ({s_fire, m_fire})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Next-state logic; report marks the cycle the packet is fully drained.
  always_comb begin
    state_next = state;
    report     = 1'b0;
    case (state)
      IDLE:    if (ctrl_start) state_next = RUN;
      RUN:     if (s_fire && s_axis_tlast) state_next = DRAIN;
      DRAIN: begin
        if (count == 2'd0) begin
          report     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!areset_n) state <= IDLE;
    else           state <= state_next;
  end

  // Registered s-side ready: open only in RUN and only while an entry will be free.
  always_ff @(posedge aclk) begin
    if (!areset_n) s_ready_q <= 1'b0;
    else           s_ready_q <= (state_next == RUN) && (count_next != 2'd2);
  end

  // Skid pointers and occupancy.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (s_fire) wr_ptr <= ~wr_ptr;
      if (m_fire) rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  // Skid payload storage.
  always_ff @(posedge aclk) begin
    // NOTE: payload storage has no reset; outputs are gated by valid, so stale contents never reach a port.
    if (s_fire) begin
      data_mem[wr_ptr] <= s_axis_tdata;
      keep_mem[wr_ptr] <= s_axis_tkeep;
      last_mem[wr_ptr] <= s_axis_tlast;
    end
  end

  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = m_valid ? data_mem[rd_ptr] : '0;
  assign m_axis_tkeep  = m_valid ? keep_mem[rd_ptr] : '0;
  assign m_axis_tlast  = m_valid ? last_mem[rd_ptr] : 1'b0;

  // Mask dropped bytes to zero, then fold lanes and count kept bytes.
  always_comb begin
    masked     = '0;
    beat_sum   = '0;
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      masked[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
      beat_bytes       = beat_bytes + C_COUNT_WIDTH'(s_axis_tkeep[i]);
    end
    for (int l = 0; l < N_LANES; l++) begin
      beat_sum = beat_sum + masked[l*C_LANE_WIDTH +: C_LANE_WIDTH];
    end
  end

  // Packet accumulators: cleared on an accepted start, updated on each accepted beat.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      sum_q   <= '0;
      beats_q <= '0;
      bytes_q <= '0;
    end else if (state == IDLE && ctrl_start) begin
      sum_q   <= '0;
      beats_q <= '0;
      bytes_q <= '0;
    end else if (s_fire) begin
      sum_q   <= sum_q + beat_sum;
      beats_q <= beats_q + C_COUNT_WIDTH'(1);
      bytes_q <= bytes_q + beat_bytes;
    end
  end

  // One-cycle report strobe.
  always_ff @(posedge aclk) begin
    if (!areset_n) sum_valid_q <= 1'b0;
    else           sum_valid_q <= report;
  end

  assign s_axis_tready = s_ready_q;
  assign busy          = (state != IDLE);
  assign sum_valid     = sum_valid_q;
  assign sum_data      = sum_q;
  assign beat_count    = beats_q;
  assign byte_count    = bytes_q;

endmodule

// File: tb/tb_finn_rtl_krnl_final_example_axis_checksum.sv
// Directed bench for the checksum stage: a packet-level model predicts every
// m-side beat and every report; a negedge monitor compares the DUT against it.
module tb_finn_rtl_krnl_final_example_axis_checksum;

  localparam int DW = 512;
  localparam int LW = 32;
  localparam int CW = 32;
  localparam int KW = DW / 8;
  localparam int NL = DW / LW;

  logic          aclk;
  logic          areset_n;
  logic          ctrl_start;
  logic          busy;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          sum_valid;
  logic [LW-1:0] sum_data;
  logic [CW-1:0] beat_count;
  logic [CW-1:0] byte_count;

  finn_rtl_krnl_final_example_axis_checksum #(
    .C_AXIS_TDATA_WIDTH(DW), .C_LANE_WIDTH(LW), .C_COUNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .ctrl_start(ctrl_start), .busy(busy),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .sum_valid(sum_valid), .sum_data(sum_data),
    .beat_count(beat_count), .byte_count(byte_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [LW-1:0] sum;
    logic [CW-1:0] beats;
    logic [CW-1:0] bytes;
  } rep_t;

  beat_t exp_q[$];
  rep_t  rep_q[$];

  int checks  = 0;
  int errors  = 0;
  int reports_seen = 0;

  logic [LW-1:0] mdl_sum;
  logic [CW-1:0] mdl_beats;
  logic [CW-1:0] mdl_bytes;

  bit rand_rdy = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Kept bytes summed by their position inside a lane, modulo 2^LW.
  function automatic logic [LW-1:0] model_beat_sum(input logic [DW-1:0] d, input logic [KW-1:0] k);
    logic [LW-1:0] s;
    s = '0;
    for (int b = 0; b < KW; b++)
      if (k[b]) s = s + (LW'(d[8*b +: 8]) << (8 * (b % (LW/8))));
    return s;
  endfunction

  function automatic logic [DW-1:0] fill_lanes(input logic [LW-1:0] v);
    logic [DW-1:0] d;
    for (int l = 0; l < NL; l++) d[l*LW +: LW] = v;
    return d;
  endfunction

  task automatic start_pkt();
    mdl_sum = '0; mdl_beats = '0; mdl_bytes = '0;
    ctrl_start = 1'b1;
    @(posedge aclk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    logic  acc;
    beat_t b;
    rep_t  r;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    acc = 1'b0;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check("s_accept", {{(DW-1){1'b0}}, acc}, 1);
    if (acc) begin
      b.data = d; b.keep = k; b.last = l;
      exp_q.push_back(b);
      mdl_sum   = mdl_sum + model_beat_sum(d, k);
      mdl_beats = mdl_beats + 1;
      mdl_bytes = mdl_bytes + CW'($countones(k));
      if (l) begin
        r.sum = mdl_sum; r.beats = mdl_beats; r.bytes = mdl_bytes;
        rep_q.push_back(r);
      end
    end
  endtask

  task automatic wait_report();
    for (int n = 0; n < 3000 && rep_q.size() != 0; n++) @(posedge aclk);
    #1;
    check("report_wait", rep_q.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    @(posedge aclk); #1;
    exp_q.delete(); rep_q.delete();
    mdl_sum = '0; mdl_beats = '0; mdl_bytes = '0;
    @(negedge aclk);
    check("rst_busy",      busy, 0);
    check("rst_s_tready",  s_axis_tready, 0);
    check("rst_m_tvalid",  m_axis_tvalid, 0);
    check("rst_m_tdata",   m_axis_tdata, 0);
    check("rst_m_tkeep",   m_axis_tkeep, 0);
    check("rst_m_tlast",   m_axis_tlast, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_sum_data",  sum_data, 0);
    check("rst_beat_cnt",  beat_count, 0);
    check("rst_byte_cnt",  byte_count, 0);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(posedge aclk); #1;
  endtask

  // Random m-side back-pressure when enabled.
  always @(posedge aclk) begin
    #1;
    if (rand_rdy) m_axis_tready = ($urandom_range(0, 1) == 1);
  end

  // Monitor: compares m-side beats and reports against the model queues.
  logic          prev_stall = 1'b0;
  logic          prev_sv    = 1'b0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  always @(negedge aclk) begin
    if (areset_n) begin
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data",  m_axis_tdata, prev_data);
        check("stall_keep",  m_axis_tkeep, prev_keep);
        check("stall_last",  m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("m_beat_expected", 0, 1);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("m_data", m_axis_tdata, b.data);
          check("m_keep", m_axis_tkeep, b.keep);
          check("m_last", m_axis_tlast, b.last);
        end
      end
      if (sum_valid) begin
        reports_seen++;
        check("sum_valid_single", prev_sv, 0);
        check("drained_before_report", exp_q.size(), 0);
        if (rep_q.size() == 0) begin
          check("report_expected", 0, 1);
        end else begin
          rep_t r;
          r = rep_q.pop_front();
          check("rep_sum",   sum_data,   r.sum);
          check("rep_beats", beat_count, r.beats);
          check("rep_bytes", byte_count, r.bytes);
        end
      end
    end
    prev_stall = areset_n && m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_keep  = m_axis_tkeep;
    prev_last  = m_axis_tlast;
    prev_sv    = areset_n && sum_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int            seen;
    areset_n = 1'b0; ctrl_start = 1'b0; m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    do_reset();
    m_axis_tready = 1'b1;

    // 1: four beats of all-ones lanes.
    start_pkt();
    for (int i = 0; i < 4; i++) send_beat(fill_lanes(32'd1), '1, i == 3);
    wait_report();
    check("t1_sum",   sum_data, 64);
    check("t1_beats", beat_count, 4);
    check("t1_bytes", byte_count, 256);
    check("t1_reports", reports_seen, 1);

    // 2: modular wrap of the lane sum.
    start_pkt();
    send_beat(fill_lanes(32'hFFFF_FFFF), '1, 1'b0);
    d = '0; d[31:0] = 32'h10;
    send_beat(d, '1, 1'b1);
    wait_report();
    check("t2_sum",   sum_data, 0);
    check("t2_beats", beat_count, 2);
    check("t2_bytes", byte_count, 128);

    // 3: partial keep, dropped bytes carry garbage that must be ignored.
    start_pkt();
    d = fill_lanes(32'hDEAD_BEEF); d[31:0] = 32'hAABB_CCDD;
    k = '0; k[3:0] = 4'hF;
    send_beat(d, k, 1'b1);
    wait_report();
    check("t3_sum",   sum_data, 32'hAABB_CCDD);
    check("t3_beats", beat_count, 1);
    check("t3_bytes", byte_count, 4);

    // 3b: zero-byte beat counts as a beat and adds nothing.
    start_pkt();
    send_beat(fill_lanes(32'hFFFF_FFFF), '0, 1'b0);
    send_beat(fill_lanes(32'd3), '1, 1'b1);
    wait_report();
    check("t3b_sum",   sum_data, 48);
    check("t3b_beats", beat_count, 2);
    check("t3b_bytes", byte_count, 64);

    // Full skid: two beats held with m side stalled closes the s side.
    m_axis_tready = 1'b0;
    start_pkt();
    send_beat(fill_lanes(32'd7), '1, 1'b0);
    send_beat(fill_lanes(32'd8), '1, 1'b0);
    @(negedge aclk);
    check("full_s_tready", s_axis_tready, 0);
    check("full_m_tvalid", m_axis_tvalid, 1);
    check("full_busy",     busy, 1);
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    send_beat(fill_lanes(32'd9), '1, 1'b1);
    wait_report();
    check("full_sum", sum_data, 384);

    // 4: 100 beats under random back-pressure.
    seen = reports_seen;
    start_pkt();
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      for (int l = 0; l < NL; l++) d[l*LW +: LW] = $urandom;
      if ($urandom_range(0, 3) == 0) k = {$urandom, $urandom};
      else                           k = '1;
      send_beat(d, k, i == 99);
    end
    wait_report();
    rand_rdy = 0;
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    check("t4_reports", reports_seen, seen + 1);
    check("t4_beats", beat_count, 100);

    // 5: reset mid-packet, then a fresh short packet.
    seen = reports_seen;
    start_pkt();
    for (int i = 0; i < 3; i++) send_beat(fill_lanes(32'd5), '1, 1'b0);
    do_reset();
    m_axis_tready = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    check("t5_no_report", reports_seen, seen);
    start_pkt();
    send_beat(fill_lanes(32'd2), '1, 1'b0);
    send_beat(fill_lanes(32'd2), '1, 1'b1);
    wait_report();
    check("t5_sum",   sum_data, 64);
    check("t5_beats", beat_count, 2);
    check("t5_bytes", byte_count, 128);

    // 6: start pulse during RUN must be ignored.
    start_pkt();
    send_beat(fill_lanes(32'd1), '1, 1'b0);
    ctrl_start = 1'b1;
    @(posedge aclk); #1;
    ctrl_start = 1'b0;
    send_beat(fill_lanes(32'd1), '1, 1'b0);
    send_beat(fill_lanes(32'd1), '1, 1'b1);
    wait_report();
    check("t6_sum",   sum_data, 48);
    check("t6_beats", beat_count, 3);
    check("t6_bytes", byte_count, 192);
    check("t6_idle",  busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
